conv_mac_acc: RTL and testbench
===============================

CONV_MAC_ACC -- requirements
Module: conv_mac_acc

Interface
REQ-001 SHALL have parameter DATA_W, default 12, meaning signed pixel width.
REQ-002 SHALL have parameter WGT_W, default 8, meaning signed weight width.
REQ-003 SHALL have parameter KS, default 5, meaning kernel side (KS*KS taps).
REQ-004 SHALL have parameter CH, default 3, meaning input channels per output.
REQ-005 SHALL have parameters ACC_W, default 28 (accumulator width), OUT_W, default 14 (output width), and SHIFT, default 6 (fraction bits dropped).
REQ-006 SHALL have port clk, input, 1 bit, the single clock.
REQ-007 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-008 SHALL have port valid_in, input, 1 bit, meaning one channel window is presented.
REQ-009 SHALL have port ready_in, output, 1 bit, meaning a window beat can be accepted.
REQ-010 SHALL have port win_data, input, KS*KS*DATA_W bits; tap i occupies bits [i*DATA_W +: DATA_W].
REQ-011 SHALL have port wgt_we, input, 1 bit, meaning weight write strobe.
REQ-012 SHALL have port wgt_addr, input, $clog2(CH*KS*KS) bits, addressed as ch*KS*KS+tap.
REQ-013 SHALL have port wgt_data, input, WGT_W bits, the signed weight value.
REQ-014 SHALL have port wgt_drop, output, 1 bit, a one-cycle pulse when a write is discarded.
REQ-015 SHALL have port conv_out, output, OUT_W bits, the signed result.
REQ-016 SHALL have port valid_out, output, 1 bit, meaning conv_out holds a result.
REQ-017 SHALL have port ready_out, input, 1 bit, meaning the downstream consumer accepts the result.

Function
REQ-018 SHALL implement the two states ACC and HOLD.
REQ-019 SHALL drive ready_in = (state==ACC).
REQ-020 SHALL count beats with ch_cnt (0..CH-1); beat k of a frame uses weights of channel k.
REQ-021 SHALL, on each accepted beat (valid_in & ready_in), load acc <= dot(win, W[ch_cnt]) when ch_cnt==0, and acc <= acc + dot(...) otherwise.
REQ-022 SHALL form all products and sums at full signed precision, sign-extended to ACC_W, with no intermediate truncation.
REQ-023 SHALL, on the beat with ch_cnt==CH-1, wrap ch_cnt to 0 and move to HOLD; valid_out rises the next cycle, giving a latency of 1 cycle after the last beat.
REQ-024 SHALL, in HOLD, hold valid_out=1 with conv_out stable until ready_out=1, then return to ACC with valid_out=0 the next cycle.
REQ-025 SHALL compute conv_out = acc >>> SHIFT (arithmetic, floor), saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-026 SHALL ignore valid_in while in HOLD; no beat is lost because ready_in=0.
REQ-027 SHALL write a weight the cycle after wgt_we only when state==ACC, ch_cnt==0, and no beat is accepted that cycle; otherwise the write is dropped and wgt_drop pulses one cycle later.
REQ-028 SHALL keep weight storage uninitialised by reset; weights persist across frames and resets.

Reset
REQ-029 SHALL set state=ACC, ch_cnt=0, acc=0, valid_out=0, wgt_drop=0 on rst, which overrides any in-flight beat or handshake.
REQ-030 SHALL discard a frame in progress at reset; the next accepted beat is treated as channel 0.

Configuration
REQ-031 SHALL, with CONV_RELU_EN defined, clamp negative saturated results to 0 on conv_out; without it, conv_out is the signed saturated value.

Structure
REQ-032 SHALL place in shared package conv_pkg the state enum (ACC, HOLD) and the default parameter constants.
REQ-033 SHALL use sub-module conv_dot: a combinational KS*KS signed dot product of one window and one weight set.

Verification
REQ-034 SHALL cover: defaults, all pixels 64, all weights 1, 3 beats -> conv_out=75, valid_out 1 cycle after beat 3.
REQ-035 SHALL cover: all weights -1, pixels 64 -> conv_out=-75; with CONV_RELU_EN -> 0.
REQ-036 SHALL cover: pixels 2047, weights 127 -> acc=19497675, conv_out=8191 (saturated).
REQ-037 SHALL cover: ready_out low 3 cycles after result -> valid_out, conv_out held; ready_in=0; valid_in ignored.
REQ-038 SHALL cover: rst after 2 beats, then a full frame of the pixels-64/weights-1 case -> conv_out=75 with no carry-over.
REQ-039 SHALL cover: wgt_we at ch_cnt==1 -> wgt_drop pulses, weight unchanged, result still 75.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and default sizing for the conv_mac_acc convolution MAC.
package conv_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } conv_state_e;

  localparam int DEF_DATA_W = 12;
  localparam int DEF_WGT_W  = 8;
  localparam int DEF_KS     = 5;
  localparam int DEF_CH     = 3;
  localparam int DEF_ACC_W  = 28;
  localparam int DEF_OUT_W  = 14;
  localparam int DEF_SHIFT  = 6;

endpackage

// File: rtl/conv_dot.sv
// Combinational signed dot product of one KS*KS window with one weight set, full precision.
module conv_dot
  import conv_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int WGT_W  = DEF_WGT_W,
  parameter int NT     = DEF_KS * DEF_KS,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic [NT*DATA_W-1:0]     win_i,
  input  logic [NT*WGT_W-1:0]      wgt_i,
  output logic signed [ACC_W-1:0]  dot_o
);

  localparam int PW = DATA_W + WGT_W;

  logic signed [PW-1:0] prod [NT];

  always_comb begin
    for (int t = 0; t < NT; t++) begin
      prod[t] = PW'($signed(win_i[t*DATA_W +: DATA_W])) *
                PW'($signed(wgt_i[t*WGT_W +: WGT_W]));
    end
  end

  always_comb begin
    dot_o = '0;
    for (int t = 0; t < NT; t++) begin
      dot_o = dot_o + ACC_W'(prod[t]);
    end
  end

endmodule

// File: rtl/conv_mac_acc.sv
// CH-beat KS*KS MAC; result valid 1 cycle after last beat; CONV_RELU_EN clamps negatives to 0.
// ready_in drops while a result waits in HOLD for ready_out; weight writes land only between frames.
module conv_mac_acc
  import conv_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int WGT_W  = DEF_WGT_W,
  parameter int KS     = DEF_KS,
  parameter int CH     = DEF_CH,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int SHIFT  = DEF_SHIFT,
  localparam int NT    = KS * KS,
  localparam int NW    = CH * NT,
  localparam int AW    = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [NT*DATA_W-1:0]    win_data,
  input  logic                    wgt_we,
  input  logic [AW-1:0]           wgt_addr,
  input  logic [WGT_W-1:0]        wgt_data,
  output logic                    wgt_drop,
  output logic [OUT_W-1:0]        conv_out,
  output logic                    valid_out,
  input  logic                    ready_out
);

  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  conv_state_e                 state_q;
  logic [CW-1:0]               ch_q;
  logic signed [ACC_W-1:0]     acc_q, acc_d;
  logic                        vout_q;
  logic                        drop_q;
  logic signed [WGT_W-1:0]     wmem_q [NW];

  logic                        beat;
  logic                        wr_ok;
  logic [AW-1:0]               wbase;
  logic [NT*WGT_W-1:0]         wsel;
  logic signed [ACC_W-1:0]     dot;
  logic signed [ACC_W-1:0]     acc_sh;
  logic [OUT_W-1:0]            res;

  assign ready_in = (state_q == ACC);
  assign beat     = valid_in & ready_in;
  // Writes only between frames so a running frame never sees a weight change mid-way.
  assign wr_ok    = wgt_we & (state_q == ACC) & (ch_q == '0) & ~beat;

  always_comb begin
    wbase = AW'(ch_q) * AW'(NT);
    wsel  = '0;
    for (int t = 0; t < NT; t++) begin
      wsel[t*WGT_W +: WGT_W] = wmem_q[wbase + AW'(t)];
    end
  end

  conv_dot #(
    .DATA_W (DATA_W),
    .WGT_W  (WGT_W),
    .NT     (NT),
    .ACC_W  (ACC_W)
  ) u_dot (
    .win_i  (win_data),
    .wgt_i  (wsel),
    .dot_o  (dot)
  );

  assign acc_d = (ch_q == '0) ? dot : (acc_q + dot);

  // Weight RAM is deliberately outside reset so coefficients survive it.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      wmem_q[wgt_addr] <= wgt_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
      ch_q    <= '0;
      acc_q   <= '0;
      vout_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= wgt_we & ~wr_ok;
      case (state_q)
        ACC: begin
          if (beat) begin
            acc_q <= acc_d;
            if (ch_q == CW'(CH - 1)) begin
              ch_q    <= '0;
              state_q <= HOLD;
              vout_q  <= 1'b1;
            end else begin
              ch_q <= ch_q + CW'(1);
            end
          end
        end
        HOLD: begin
          if (ready_out) begin
            state_q <= ACC;
            vout_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ACC;
          vout_q  <= 1'b0;
        end
      endcase
    end
  end

  assign acc_sh = acc_q >>> SHIFT;

  always_comb begin
    if (acc_sh > SAT_MAX) begin
      res = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (acc_sh < SAT_MIN) begin
      res = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      res = acc_sh[OUT_W-1:0];
    end
  end

`ifdef CONV_RELU_EN
  assign conv_out = res[OUT_W-1] ? '0 : res;
`else
  assign conv_out = res;
`endif

  assign valid_out = vout_q;
  assign wgt_drop  = drop_q;

endmodule

// File: tb/tb_conv_mac_acc.sv
// Scoreboard bench for conv_mac_acc with directed frames and hand-computed results.
module tb_conv_mac_acc;

  localparam int DATA_W = 12;
  localparam int WGT_W  = 8;
  localparam int KS     = 5;
  localparam int CH     = 3;
  localparam int NT     = KS * KS;
  localparam int AW     = $clog2(CH * NT);

`ifdef CONV_RELU_EN
  localparam int NEG_RES = 0;
`else
  localparam int NEG_RES = -75;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  valid_in = 1'b0;
  logic                  ready_in;
  logic [NT*DATA_W-1:0]  win_data = '0;
  logic                  wgt_we = 1'b0;
  logic [AW-1:0]         wgt_addr = '0;
  logic [WGT_W-1:0]      wgt_data = '0;
  logic                  wgt_drop;
  logic [13:0]           conv_out;
  logic                  valid_out;
  logic                  ready_out = 1'b1;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  conv_mac_acc dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .win_data  (win_data),
    .wgt_we    (wgt_we),
    .wgt_addr  (wgt_addr),
    .wgt_data  (wgt_data),
    .wgt_drop  (wgt_drop),
    .conv_out  (conv_out),
    .valid_out (valid_out),
    .ready_out (ready_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: consumes a result whenever it is handed off downstream.
  always @(negedge clk) begin
    if (!rst && valid_out && ready_out) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got %0d expected no output", $signed(conv_out));
      end else begin
        check("sb_result", $signed(conv_out), exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_win(input int pix);
    for (int t = 0; t < NT; t++) begin
      win_data[t*DATA_W +: DATA_W] = DATA_W'(pix);
    end
  endtask

  task automatic load_weights(input int w);
    for (int a = 0; a < CH * NT; a++) begin
      wgt_we   = 1'b1;
      wgt_addr = AW'(a);
      wgt_data = WGT_W'(w);
      tick();
    end
    wgt_we = 1'b0;
    check("wgt_no_drop", 32'(wgt_drop), 0);
  endtask

  task automatic send_beat(input int pix);
    int n;
    n = 0;
    set_win(pix);
    valid_in = 1'b1;
    while (!ready_in && n < 50) begin
      tick();
      n++;
    end
    check("beat_ready", 32'(ready_in), 1);
    tick();
    valid_in = 1'b0;
  endtask

  task automatic frame(input int pix);
    for (int b = 0; b < CH; b++) send_beat(pix);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(ready_in && !valid_out) && n < 50) begin
      tick();
      n++;
    end
    check("idle", 32'(ready_in && !valid_out), 1);
  endtask

  initial begin
    int n;
    tick();
    tick();
    check("rst_valid_out", 32'(valid_out), 0);
    check("rst_ready_in", 32'(ready_in), 1);
    check("rst_wgt_drop", 32'(wgt_drop), 0);
    rst = 1'b0;
    tick();

    // 64 * 1 * 25 taps * 3 ch = 4800 -> >>6 = 75; valid one cycle after beat 3
    load_weights(1);
    exp_q.push_back(75);
    send_beat(64);
    send_beat(64);
    check("lat_early", 32'(valid_out), 0);
    send_beat(64);
    check("lat_1cyc", 32'(valid_out), 1);
    wait_idle();

    // Negative weights: -4800 -> -75
    load_weights(-1);
    exp_q.push_back(NEG_RES);
    frame(64);
    wait_idle();

    // 2047 * 127 * 75 = 19497675 -> >>6 = 304651, saturates to 8191
    load_weights(127);
    exp_q.push_back(8191);
    frame(2047);
    wait_idle();

    // Backpressure: result held, ready_in low, extra valid_in ignored
    load_weights(1);
    ready_out = 1'b0;
    exp_q.push_back(75);
    frame(64);
    for (int i = 0; i < 3; i++) begin
      check("hold_valid", 32'(valid_out), 1);
      check("hold_data", $signed(conv_out), 75);
      check("hold_ready_in", 32'(ready_in), 0);
      set_win(500);
      valid_in = 1'b1;
      tick();
    end
    valid_in  = 1'b0;
    ready_out = 1'b1;
    wait_idle();
    exp_q.push_back(75);
    frame(64);
    wait_idle();

    // Reset after two beats of a different pixel: no carry-over
    send_beat(100);
    send_beat(100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_ready_in", 32'(ready_in), 1);
    check("midrst_valid_out", 32'(valid_out), 0);
    exp_q.push_back(75);
    frame(64);
    wait_idle();

    // Weight write at ch_cnt==1 is dropped and pulses wgt_drop for one cycle
    exp_q.push_back(75);
    send_beat(64);
    wgt_we   = 1'b1;
    wgt_addr = AW'(NT);
    wgt_data = WGT_W'(50);
    tick();
    wgt_we = 1'b0;
    check("drop_pulse", 32'(wgt_drop), 1);
    tick();
    check("drop_clear", 32'(wgt_drop), 0);
    send_beat(64);
    send_beat(64);
    wait_idle();

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("sb_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
